// File: rtl/and_serial_reducer.sv
// -----------------------------------------------------------------------------
// and_serial_reducer
// Bit-serial AND reduction of an N-bit word. A word is accepted in IDLE, its
// bits are folded into an accumulator one per cycle (LSB first) in RUN, and the
// result is held in DONE until the consumer takes it.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : word on `in` is offered
//   in_ready   : block can accept a word (combinational, IDLE only)
//   in         : N-bit operand, in[0] processed first
//   out_valid  : result on y is valid (registered)
//   out_ready  : consumer accepts y
//   y          : AND-reduction of the accepted word (registered)
// -----------------------------------------------------------------------------
module and_serial_reducer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         y
);

    localparam int unsigned CW = (N < 2) ? 1 : $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("and_serial_reducer: N must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_sreg;
    logic            r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic            r_y;
    logic            w_last;
    logic            w_acc_next;

    // Counter reaching N-1 marks the cycle that folds in the final bit.
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_acc_next = r_acc & r_sreg[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Output logic: ready depends on state alone
    always_comb begin
        in_ready = 1'b0;
        if (r_state == S_IDLE) begin
            in_ready = 1'b1;
        end
    end

    // Datapath: capture, serial fold, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg      <= '0;
            r_acc       <= 1'b1;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_y         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sreg <= in;
                        r_acc  <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_sreg <= r_sreg >> 1;
                    // Counter stops at N-1 so it never wraps for any N.
                    if (w_last) begin
                        r_y         <= w_acc_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule

// File: tb/tb_and_serial_reducer.sv
// -----------------------------------------------------------------------------
// tb_and_serial_reducer
// Self-checking bench: an N=8 instance exercised with directed and random words,
// stalls, input corruption during processing and mid-word resets; N=2 and N=5
// instances swept exhaustively back-to-back. Expected results come from the
// plain rule y = &word with a fixed N-edge latency and N+2 acceptance spacing.
// -----------------------------------------------------------------------------
module tb_and_serial_reducer;

    localparam int unsigned N8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- N=8 DUT
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N8-1:0] in_w;
    logic          out_valid;
    logic          out_ready;
    logic          y;

    and_serial_reducer #(.N(N8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    // Inputs that must have no effect while a word is in flight.
    task automatic garbage(input bit zero_in);
        in_valid  = 1'($urandom);
        in_w      = zero_in ? 8'h00 : 8'($urandom);
        out_ready = 1'($urandom);
    endtask

    // One full transaction: accept w, check fixed latency, stall, then drain.
    task automatic txn8(input logic [7:0] w, input int stall, input bit zero_in);
        logic exp_y;
        exp_y = &w;
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_w      = w;
        out_ready = 1'($urandom);
        @(posedge clk);
        #1 garbage(zero_in);
        for (int k = 1; k <= int'(N8); k++) begin
            @(negedge clk);
            check("run_ov", out_valid, 0);
            check("run_rdy", in_ready, 0);
            @(posedge clk);
            #1 garbage(zero_in);
            if (k == int'(N8)) out_ready = 1'b0;
        end
        @(negedge clk);
        check("done_ov", out_valid, 1);
        check("done_y", y, exp_y);
        check("done_rdy", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1 garbage(zero_in);
            out_ready = 1'b0;
            @(negedge clk);
            check("stall_ov", out_valid, 1);
            check("stall_y", y, exp_y);
            check("stall_rdy", in_ready, 0);
        end
        // out_ready and in_valid together in DONE: only the output completes.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_w      = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_ov", out_valid, 0);
        check("drain_rdy", in_ready, 1);
    endtask

    // Accept w, then reset on the k-th cycle after acceptance.
    task automatic abort8(input logic [7:0] w, input int k);
        @(negedge clk);
        check("abort_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_w      = w;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_rdy", in_ready, 1);
        check("abort_ov", out_valid, 0);
        check("abort_y", y, 0);
        for (int i = 0; i < int'(N8) + 2; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end
    endtask

    // ------------------------------------------- exhaustive N=2 / N=5 sweeps
    for (genvar gi = 0; gi < 2; gi++) begin : g_ex
        localparam int unsigned NN = (gi == 0) ? 2 : 5;

        logic          rst_x;
        logic          iv;
        logic          irdy;
        logic [NN-1:0] in_x;
        logic          ov;
        logic          ordy;
        logic          yx;
        bit            done_l = 1'b0;

        and_serial_reducer #(.N(NN)) u_dut (
            .clk       (clk),
            .rst       (rst_x),
            .in_valid  (iv),
            .in_ready  (irdy),
            .in        (in_x),
            .out_valid (ov),
            .out_ready (ordy),
            .y         (yx)
        );

        initial begin
            int            acc_q[$];
            logic [NN-1:0] w_q[$];
            int            last_acc;
            int            nxt;
            int            a;
            logic [NN-1:0] wv;
            bit            hs;
            rst_x = 1'b1;
            iv    = 1'b0;
            in_x  = '0;
            ordy  = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst_x    = 1'b0;
            iv       = 1'b1;
            nxt      = 0;
            last_acc = -1;
            for (int c = 0; c < (1 << NN) * (int'(NN) + 2) + 50; c++) begin
                @(negedge clk);
                if (ov) begin
                    if (w_q.size() == 0) begin
                        check("ex_spurious", ov, 0);
                    end else begin
                        wv = w_q.pop_front();
                        a  = acc_q.pop_front();
                        check("ex_y", yx, &wv);
                        check("ex_latency", c - 1 - a, NN);
                    end
                end
                hs = iv && irdy;
                @(posedge clk);
                if (hs) begin
                    w_q.push_back(in_x);
                    acc_q.push_back(c);
                    if (last_acc >= 0) check("ex_spacing", c - last_acc, NN + 2);
                    last_acc = c;
                    nxt++;
                end
                #1;
                if (hs) begin
                    if (nxt == (1 << NN)) iv = 1'b0;
                    else                  in_x = NN'(nxt);
                end
                if (nxt == (1 << NN) && w_q.size() == 0) break;
            end
            check("ex_all_words", nxt, 1 << NN);
            check("ex_all_results", w_q.size(), 0);
            done_l = 1'b1;
        end
    end

    // ------------------------------------------------------------ main flow
    initial begin
        logic [7:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_w      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", in_ready, 1);
        check("rst_ov", out_valid, 0);
        check("rst_y", y, 0);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;

        txn8(8'hFF, 0, 1'b0);
        txn8(8'hFE, 0, 1'b0);
        txn8(8'h7F, 0, 1'b0);
        txn8(8'hFF, 5, 1'b0);
        txn8(8'hFF, 1, 1'b1);
        txn8(8'h00, 2, 1'b0);

        abort8(8'hFF, 4);
        txn8(8'hFF, 0, 1'b0);
        abort8(8'hFF, int'(N8) + 1);
        txn8(8'hFF, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0) w = 8'hFF;
            else if ($urandom_range(0, 2) == 0) w = 8'hFF ^ (8'h01 << $urandom_range(0, 7));
            txn8(w, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 2000 && !(g_ex[0].done_l && g_ex[1].done_l); i++) begin
            @(posedge clk);
        end
        check("ex_finished", {30'd0, g_ex[1].done_l, g_ex[0].done_l}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/and_serial_reducer.md
AND_SERIAL_REDUCER -- requirements
Module: and_serial_reducer

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits; elaboration SHALL fail with an $error when N < 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the word on in is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 SHALL have port in, input, N bits: operand word, with in[0] processed first.
REQ-007 SHALL have port out_valid, output, 1 bit: result on y is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-009 SHALL have port y, output, 1 bit: the AND-reduction of the accepted word.

Function
REQ-010 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE, and in_ready SHALL be combinational on state only.
REQ-012 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1: capture in into an N-bit shift register, set the accumulator to 1, clear the bit counter, go to RUN.
REQ-013 SHALL, in RUN, once per cycle: set acc <= acc & sreg[0], shift sreg right by 1, and increment the counter.
REQ-014 SHALL size the counter at $clog2(N) bits and leave RUN on the edge where the counter equals N-1, with no wrap past N-1.
REQ-015 SHALL hold N-1 as the terminal count for every N >= 2, including non-powers-of-two.
REQ-016 SHALL enter DONE on the edge that processes the last bit, register y = AND of all N captured bits, and raise out_valid.
REQ-017 SHALL have fixed latency: with acceptance on edge t, out_valid=1 SHALL first be visible after edge t+N, and processing SHALL take N cycles with no early termination on a zero bit.
REQ-018 SHALL, in DONE, hold out_valid=1 and y stable until a rising edge with out_ready=1, then go to IDLE and clear out_valid.
REQ-019 SHALL keep in_ready=0 in DONE, so simultaneous out_ready=1 and in_valid=1 in DONE completes the output only; the new word is accepted no earlier than the next cycle in IDLE.
REQ-020 SHALL ignore changes on in and in_valid during RUN and DONE, with the captured word governing the result.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL set y = 1 if and only if every bit of the accepted word is 1.
REQ-023 SHALL yield one result per accepted word, with peak throughput of one word per N+2 cycles.

Reset
REQ-024 SHALL, while rst=1 on a rising edge: state <= IDLE, counter <= 0, acc <= 1, sreg <= 0, out_valid <= 0, y <= 0; in_ready SHALL be 1 after reset.
REQ-025 SHALL let rst take priority over every handshake: rst asserted in RUN or DONE SHALL discard the word in progress with no out_valid pulse.
REQ-026 SHALL have no asynchronous behaviour: rst is sampled only on clk.

Verification
REQ-027 SHALL be verified with N=8, in=8'hFF accepted at edge t -> out_valid rises after edge t+8, y=1.
REQ-028 SHALL be verified with N=8, in=8'hFE (LSB zero) and separately 8'h7F (MSB zero) -> y=0 after 8 cycles in both cases, with no early completion.
REQ-029 SHALL be verified with N=8, in=8'hFF, out_ready held 0 for 5 cycles after out_valid -> out_valid=1, y=1 and in_ready=0 held all 5 cycles; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL be verified with in changed to 8'h00 during RUN after accepting 8'hFF -> y=1.
REQ-031 SHALL be verified with rst=1 at the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, y=0; no result for the aborted word; a subsequent 8'hFF -> y=1 after 8 cycles.
REQ-032 SHALL be verified with N=2 and N=5 instances, exhaustively over all inputs, back-to-back with out_ready=1 and in_valid=1 -> y equals the AND-reduction for every word, with the N+2 cycle spacing between acceptances.
